// File: rtl/lianliankan_defs.sv
// Shared definitions for the lianliankan board: timing defaults, button
// indices and the auto-repeat FSM state encoding.
package lianliankan_defs;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 40_000_000;
  localparam int unsigned DEF_REPEAT_RATE     = 15_000_000;
  localparam int unsigned DEF_CNT_W           = 26;

  localparam int unsigned IDX_UP    = 0;
  localparam int unsigned IDX_DOWN  = 1;
  localparam int unsigned IDX_LEFT  = 2;
  localparam int unsigned IDX_RIGHT = 3;
  localparam int unsigned IDX_SEL   = 4;

  localparam int unsigned NUM_DIR = 4;
  localparam int unsigned NUM_BTN = 5;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } rpt_state_e;

  // True when two or more bits are set.
  function automatic logic multi_hot(input logic [NUM_DIR-1:0] v);
    return (v & (v - NUM_DIR'(1))) != '0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-FF synchroniser plus debounce counter for one raw button; tracks the
// accepted level and whether a released state has been confirmed.
module btn_debounce
  import lianliankan_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_stable,
  output logic o_armed
);

  localparam logic [CNT_W-1:0] Target = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_last;
  logic             r_stable;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;

  logic             w_diff;
  logic             w_arming;
  logic [CNT_W-1:0] w_run;
  logic [CNT_W-1:0] w_cnt_inc;

  // The counter also confirms a low level after reset before arming, so a
  // button held through reset cannot fire; a sample change restarts the run.
  always_comb begin
    w_diff    = r_sync2 != r_stable;
    w_arming  = !r_armed && !r_stable && !r_sync2;
    w_run     = (r_sync2 == r_last) ? r_cnt : '0;
    w_cnt_inc = (w_run == '1) ? w_run : w_run + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_last   <= 1'b0;
      r_stable <= 1'b0;
      r_armed  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
      if (w_diff || w_arming) begin
        if (w_cnt_inc >= Target) begin
          r_cnt <= '0;
          if (w_diff) begin
            r_stable <= r_sync2;
            if (!r_sync2) r_armed <= 1'b1;
          end else begin
            r_armed <= 1'b1;
          end
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_armed  = r_armed;

endmodule

// File: rtl/btn_conditioner.sv
// Button front end: debounces five buttons, turns presses into one-cycle
// pulses, auto-repeats held directions and suppresses conflicting directions.
module btn_conditioner
  import lianliankan_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_s,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic s
);

  localparam logic [CNT_W-1:0] RptDelay = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RptRate  = CNT_W'(REPEAT_RATE);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_armed;
  logic [NUM_BTN-1:0] w_rise;
  logic [NUM_BTN-1:0] r_stable_prev;
  logic [NUM_BTN-1:0] r_pulse;
  logic [NUM_BTN-1:0] w_pulse_d;
  logic [NUM_DIR-1:0] w_fire;
  logic               w_conflict;

  rpt_state_e       r_state     [NUM_DIR];
  rpt_state_e       w_state_d   [NUM_DIR];
  logic [CNT_W-1:0] r_rpt_cnt   [NUM_DIR];
  logic [CNT_W-1:0] w_rpt_cnt_d [NUM_DIR];

  assign w_raw = {btn_s, btn_right, btn_left, btn_down, btn_up};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (w_raw[g]),
      .o_stable(w_stable[g]),
      .o_armed (w_armed[g])
    );
  end

  always_comb begin
    w_rise     = w_stable & ~r_stable_prev & w_armed;
    w_conflict = multi_hot(w_stable[NUM_DIR-1:0]);
    w_fire     = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      w_state_d[i]   = r_state[i];
      w_rpt_cnt_d[i] = r_rpt_cnt[i];
      case (r_state[i])
        StIdle: begin
          if (w_rise[i]) begin
            w_fire[i]      = 1'b1;
            w_rpt_cnt_d[i] = RptDelay;
            w_state_d[i]   = StHold;
          end
        end
        StHold, StRepeat: begin
          if (!w_stable[i]) begin
            w_rpt_cnt_d[i] = '0;
            w_state_d[i]   = StIdle;
          end else if (r_rpt_cnt[i] <= CNT_W'(1)) begin
            // Decrementing would reach zero on this edge.
            w_fire[i]      = 1'b1;
            w_rpt_cnt_d[i] = RptRate;
            w_state_d[i]   = StRepeat;
          end else begin
            w_rpt_cnt_d[i] = r_rpt_cnt[i] - CNT_W'(1);
          end
        end
        default: begin
          w_rpt_cnt_d[i] = '0;
          w_state_d[i]   = StIdle;
        end
      endcase
    end
    w_pulse_d = {w_rise[IDX_SEL], w_fire & {NUM_DIR{~w_conflict}}};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stable_prev <= '0;
      r_pulse       <= '0;
      for (int i = 0; i < NUM_DIR; i++) begin
        r_state[i]   <= StIdle;
        r_rpt_cnt[i] <= '0;
      end
    end else begin
      r_stable_prev <= w_stable;
      r_pulse       <= w_pulse_d;
      for (int i = 0; i < NUM_DIR; i++) begin
        r_state[i]   <= w_state_d[i];
        r_rpt_cnt[i] <= w_rpt_cnt_d[i];
      end
    end
  end

  assign up    = r_pulse[IDX_UP];
  assign down  = r_pulse[IDX_DOWN];
  assign left  = r_pulse[IDX_LEFT];
  assign right = r_pulse[IDX_RIGHT];
  assign s     = r_pulse[IDX_SEL];

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus randomized button traffic
// compared against an event-time reference model of the press/repeat rules.
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int CW = 8;

  typedef int iq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_s = 1'b0;
  logic up, down, left, right, s;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  int dut_q[5][$];
  int exp_q[5][$];

  // Reference model state: pipeline delay, run length of identical samples,
  // accepted level, armed flag and the time of the next scheduled repeat.
  bit m_sh1[5], m_sh2[5], m_last[5], m_st[5], m_pst[5], m_arm[5];
  int m_run[5];
  bit m_act[4];
  int m_next[4];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_s    (btn_s),
    .up       (up),
    .down     (down),
    .left     (left),
    .right    (right),
    .s        (s)
  );

  always #5 clk = ~clk;

  function automatic void model_step();
    logic [4:0] raw;
    int ndir;
    bit fire;
    bit smp;
    raw = {btn_s, btn_right, btn_left, btn_down, btn_up};
    cyc++;
    if (!rst) begin
      for (int b = 0; b < 5; b++) begin
        m_sh1[b] = 0; m_sh2[b] = 0; m_last[b] = 0; m_st[b] = 0; m_pst[b] = 0;
        m_arm[b] = 0; m_run[b] = 0;
      end
      for (int b = 0; b < 4; b++) m_act[b] = 0;
      return;
    end
    ndir = 0;
    for (int b = 0; b < 4; b++) if (m_st[b]) ndir++;
    for (int b = 0; b < 5; b++) begin
      fire = 0;
      if (m_st[b] && !m_pst[b] && m_arm[b]) begin
        fire = 1;
        if (b < 4) begin m_act[b] = 1; m_next[b] = cyc + RD; end
      end else if (b < 4 && m_st[b] && m_act[b] && cyc == m_next[b]) begin
        fire = 1;
        m_next[b] = cyc + RR;
      end
      if (b < 4 && !m_st[b]) m_act[b] = 0;
      if (fire && (b == 4 || ndir < 2)) exp_q[b].push_back(cyc);
    end
    for (int b = 0; b < 5; b++) begin
      smp = m_sh2[b];
      m_sh2[b] = m_sh1[b];
      m_sh1[b] = raw[b];
      m_pst[b] = m_st[b];
      m_run[b] = (smp == m_last[b]) ? m_run[b] + 1 : 1;
      m_last[b] = smp;
      if (smp != m_st[b] && m_run[b] >= DB) begin
        m_st[b] = smp;
        if (!smp) m_arm[b] = 1;
      end else if (!smp && !m_st[b] && m_run[b] >= DB) begin
        m_arm[b] = 1;
      end
    end
  endfunction

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (up === 1'b1)    dut_q[0].push_back(cyc);
    if (down === 1'b1)  dut_q[1].push_back(cyc);
    if (left === 1'b1)  dut_q[2].push_back(cyc);
    if (right === 1'b1) dut_q[3].push_back(cyc);
    if (s === 1'b1)     dut_q[4].push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic iq_t win(input bit use_exp, input int b, input int t0, input int t1);
    iq_t r;
    if (use_exp) begin
      for (int i = 0; i < exp_q[b].size(); i++)
        if (exp_q[b][i] >= t0 && exp_q[b][i] <= t1) r.push_back(exp_q[b][i]);
    end else begin
      for (int i = 0; i < dut_q[b].size(); i++)
        if (dut_q[b][i] >= t0 && dut_q[b][i] <= t1) r.push_back(dut_q[b][i]);
    end
    return r;
  endfunction

  task automatic test_reset();
    int t0;
    rst = 1'b0;
    tick(4);
    n_checks++;
    if ({up, down, left, right, s} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {up, down, left, right, s});
    end
    t0 = cyc + 1;
    rst = 1'b1;
    tick(20);
    for (int b = 0; b < 5; b++) begin
      n_checks++;
      if (win(0, b, t0, cyc).size() != 0) begin
        n_errors++;
        $display("FAIL idle_after_reset[%0d]: got %0d pulses expected 0", b,
                 win(0, b, t0, cyc).size());
      end
    end
  endtask

  task automatic test_clean_press();
    int k;
    iq_t q;
    k = cyc + 1;
    btn_down = 1'b1;
    tick(12);
    btn_down = 1'b0;
    tick(20);
    q = win(0, 1, k, cyc);
    n_checks++;
    if (q.size() != 1 || q[0] != k + 2 + DB) begin
      n_errors++;
      $display("FAIL clean_press_down: got %0d pulses first@%0d expected 1 @%0d",
               q.size(), (q.size() > 0) ? q[0] : -1, k + 2 + DB);
    end
    for (int b = 0; b < 5; b++) begin
      if (b == 1) continue;
      n_checks++;
      if (win(0, b, k, cyc).size() != 0) begin
        n_errors++;
        $display("FAIL clean_press_other[%0d]: got %0d pulses expected 0", b,
                 win(0, b, k, cyc).size());
      end
    end
  endtask

  task automatic test_bounce();
    int k;
    iq_t q;
    k = cyc + 1;
    for (int i = 0; i < 20; i++) begin
      btn_s = ((i / 2) % 2) == 0;
      tick(1);
    end
    btn_s = 1'b1;
    tick(12);
    btn_s = 1'b0;
    tick(15);
    q = win(0, 4, k, cyc);
    n_checks++;
    if (q.size() != 1 || q[0] != k + 20 + 2 + DB) begin
      n_errors++;
      $display("FAIL bounce_s: got %0d pulses first@%0d expected 1 @%0d",
               q.size(), (q.size() > 0) ? q[0] : -1, k + 20 + 2 + DB);
    end
  endtask

  task automatic test_auto_repeat();
    int k;
    iq_t q;
    int offs[5];
    offs = '{0, 20, 28, 36, 44};
    k = cyc + 1;
    btn_right = 1'b1;
    btn_s = 1'b1;
    tick(52);
    btn_right = 1'b0;
    btn_s = 1'b0;
    tick(20);
    q = win(0, 3, k, cyc);
    n_checks++;
    if (q.size() != 5) begin
      n_errors++;
      $display("FAIL repeat_right_count: got %0d pulses expected 5", q.size());
    end
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      n_checks++;
      if (q[i] != k + 2 + DB + offs[i]) begin
        n_errors++;
        $display("FAIL repeat_right_time[%0d]: got %0d expected %0d", i, q[i],
                 k + 2 + DB + offs[i]);
      end
    end
    q = win(0, 4, k, cyc);
    n_checks++;
    if (q.size() != 1 || q[0] != k + 2 + DB) begin
      n_errors++;
      $display("FAIL repeat_s_once: got %0d pulses first@%0d expected 1 @%0d",
               q.size(), (q.size() > 0) ? q[0] : -1, k + 2 + DB);
    end
  endtask

  task automatic test_conflict();
    int k;
    iq_t q;
    k = cyc + 1;
    btn_up = 1'b1;
    btn_left = 1'b1;
    tick(30);
    btn_left = 1'b0;
    tick(15);
    btn_up = 1'b0;
    tick(20);
    q = win(0, 0, k, cyc);
    n_checks++;
    if (q.size() != 2 || q[0] != k + 42 || q[1] != k + 50) begin
      n_errors++;
      $display("FAIL conflict_up: got %0d pulses first@%0d expected 2 @%0d,%0d",
               q.size(), (q.size() > 0) ? q[0] : -1, k + 42, k + 50);
    end
    n_checks++;
    if (win(0, 2, k, cyc).size() != 0) begin
      n_errors++;
      $display("FAIL conflict_left: got %0d pulses expected 0", win(0, 2, k, cyc).size());
    end
  endtask

  task automatic test_glitch();
    int k;
    k = cyc + 1;
    btn_left = 1'b1;
    tick(3);
    btn_left = 1'b0;
    tick(15);
    n_checks++;
    if (win(0, 2, k, cyc).size() != 0) begin
      n_errors++;
      $display("FAIL glitch_left: got %0d pulses expected 0", win(0, 2, k, cyc).size());
    end
  endtask

  task automatic test_held_through_reset();
    int k;
    int t0;
    iq_t q;
    rst = 1'b0;
    btn_up = 1'b1;
    tick(5);
    t0 = cyc + 1;
    rst = 1'b1;
    tick(50);
    n_checks++;
    if (win(0, 0, t0, cyc).size() != 0) begin
      n_errors++;
      $display("FAIL held_reset_up: got %0d pulses expected 0", win(0, 0, t0, cyc).size());
    end
    btn_up = 1'b0;
    tick(12);
    k = cyc + 1;
    btn_up = 1'b1;
    tick(10);
    btn_up = 1'b0;
    tick(20);
    q = win(0, 0, t0, cyc);
    n_checks++;
    if (q.size() != 1 || q[0] != k + 2 + DB) begin
      n_errors++;
      $display("FAIL repress_up: got %0d pulses first@%0d expected 1 @%0d",
               q.size(), (q.size() > 0) ? q[0] : -1, k + 2 + DB);
    end
  endtask

  task automatic test_reset_during_repeat();
    int k;
    int t0;
    iq_t q;
    k = cyc + 1;
    btn_right = 1'b1;
    tick(34);
    q = win(0, 3, k, cyc);
    n_checks++;
    if (q.size() != 2 || q[0] != k + 6 || q[1] != k + 26) begin
      n_errors++;
      $display("FAIL pre_reset_right: got %0d pulses expected 2 @%0d,%0d", q.size(),
               k + 6, k + 26);
    end
    rst = 1'b0;
    tick(1);
    n_checks++;
    if ({up, down, left, right, s} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_mid_repeat: got %b expected 00000", {up, down, left, right, s});
    end
    tick(2);
    t0 = cyc;
    rst = 1'b1;
    tick(40);
    n_checks++;
    if (win(0, 3, t0, cyc).size() != 0) begin
      n_errors++;
      $display("FAIL repeat_discarded: got %0d pulses expected 0", win(0, 3, t0, cyc).size());
    end
    btn_right = 1'b0;
    tick(20);
  endtask

  task automatic test_random();
    int t0;
    int hold[5];
    logic [4:0] v;
    iq_t qd;
    iq_t qe;
    v = '0;
    for (int b = 0; b < 5; b++) hold[b] = 0;
    t0 = cyc + 1;
    repeat (3000) begin
      for (int b = 0; b < 5; b++) begin
        if (hold[b] == 0) begin
          v[b] = ~v[b];
          hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                : int'($urandom_range(5, 70));
        end else begin
          hold[b]--;
        end
      end
      {btn_s, btn_right, btn_left, btn_down, btn_up} = v;
      rst = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    {btn_s, btn_right, btn_left, btn_down, btn_up} = 5'b0;
    rst = 1'b1;
    tick(40);
    for (int b = 0; b < 5; b++) begin
      qd = win(0, b, t0, cyc);
      qe = win(1, b, t0, cyc);
      n_checks++;
      if (qd.size() != qe.size()) begin
        n_errors++;
        $display("FAIL random_count[%0d]: got %0d pulses expected %0d", b, qd.size(), qe.size());
      end
      for (int i = 0; i < qe.size() && i < qd.size(); i++) begin
        n_checks++;
        if (qd[i] != qe[i]) begin
          n_errors++;
          $display("FAIL random_time[%0d][%0d]: got %0d expected %0d", b, i, qd[i], qe[i]);
          break;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_conflict();
    test_glitch();
    test_held_through_reset();
    test_reset_during_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
